// File: rtl/set_pkg.sv
// set_pkg: mode encodings, FSM states and operand field positions shared by set_circle_counter.
package set_pkg;
    localparam logic [1:0] MODE_A   = 2'b00;
    localparam logic [1:0] MODE_AND = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;
    localparam logic [1:0] MODE_TWO = 2'b11;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    localparam int FW         = 4;
    localparam int CEN_X_MSB  = 23;
    localparam int CEN_Y_MSB  = 19;
    localparam int CEN_STRIDE = 8;
    localparam int RAD_MSB    = 11;
    localparam int RAD_STRIDE = 4;

    // hit[0]=A, hit[1]=B, hit[2]=C
    function automatic logic qualify(input logic [1:0] m, input logic [2:0] hit);
        return m == MODE_A   ? hit[0] :
               m == MODE_AND ? hit[0] & hit[1] :
               m == MODE_XOR ? hit[0] ^ hit[1] :
               (hit[0] & hit[1] & ~hit[2]) | (hit[0] & ~hit[1] & hit[2]) | (~hit[0] & hit[1] & hit[2]);
    endfunction
endpackage

// File: rtl/set_in_circle.sv
// set_in_circle: combinational test of whether lattice point (x,y) lies inside or on a circle.
module set_in_circle (
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic [3:0] xc_i,
    input  logic [3:0] yc_i,
    input  logic [3:0] r_i,
    output logic       inside_o
);
    logic signed [4:0] dx, dy;
    logic [3:0] ax, ay;
    logic [7:0] sx, sy, r2;
    assign dx = $signed({1'b0, x_i}) - $signed({1'b0, xc_i});
    assign dy = $signed({1'b0, y_i}) - $signed({1'b0, yc_i});
    // squaring the magnitude keeps the products unsigned and 8 bits wide
    assign ax = dx[4] ? 4'(-dx) : dx[3:0];
    assign ay = dy[4] ? 4'(-dy) : dy[3:0];
    assign sx = {4'b0, ax} * {4'b0, ax};
    assign sy = {4'b0, ay} * {4'b0, ay};
    assign r2 = {4'b0, r_i} * {4'b0, r_i};
    assign inside_o = ({1'b0, sx} + {1'b0, sy}) <= {1'b0, r2};
endmodule

// File: rtl/set_circle_counter.sv
// set_circle_counter: scans a GRIDxGRID lattice and counts points meeting a three-circle set condition.
// Define SET_DUAL_POINT_EN to evaluate two adjacent points per clock (GRID must be even).
module set_circle_counter
    import set_pkg::*;
#(
    parameter int GRID = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] central,
    input  logic [11:0] radius,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        valid,
    output logic [7:0]  candidate
);
    localparam logic [3:0] G = 4'(GRID);

    state_e      state_q;
    logic [3:0]  x_q, y_q;
    logic [7:0]  cnt_q, cand_q;
    logic [23:0] cen_q;
    logic [11:0] rad_q;
    logic [1:0]  mode_q;
    logic        busy_q, valid_q;
    logic [2:0]  hit0;
    logic [1:0]  inc_d;
    logic [3:0]  x_step_d;
    logic        row_end_d, last_d;

    for (genvar k = 0; k < 3; k++) begin : g_pt0
        set_in_circle u_pt0 (
            .x_i     (x_q),
            .y_i     (y_q),
            .xc_i    (cen_q[CEN_X_MSB - CEN_STRIDE*k -: FW]),
            .yc_i    (cen_q[CEN_Y_MSB - CEN_STRIDE*k -: FW]),
            .r_i     (rad_q[RAD_MSB - RAD_STRIDE*k -: FW]),
            .inside_o(hit0[k])
        );
    end

`ifdef SET_DUAL_POINT_EN
    logic [2:0] hit1;
    logic [3:0] x1;
    assign x1 = x_q + 4'd1;
    for (genvar k = 0; k < 3; k++) begin : g_pt1
        set_in_circle u_pt1 (
            .x_i     (x1),
            .y_i     (y_q),
            .xc_i    (cen_q[CEN_X_MSB - CEN_STRIDE*k -: FW]),
            .yc_i    (cen_q[CEN_Y_MSB - CEN_STRIDE*k -: FW]),
            .r_i     (rad_q[RAD_MSB - RAD_STRIDE*k -: FW]),
            .inside_o(hit1[k])
        );
    end
    assign inc_d     = {1'b0, qualify(mode_q, hit0)} + {1'b0, qualify(mode_q, hit1)};
    assign row_end_d = x1 == G;
    assign x_step_d  = 4'd2;
`else
    assign inc_d     = {1'b0, qualify(mode_q, hit0)};
    assign row_end_d = x_q == G;
    assign x_step_d  = 4'd1;
`endif
    assign last_d = row_end_d && y_q == G;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            cand_q  <= 8'd0;
            cnt_q   <= 8'd0;
            x_q     <= 4'd1;
            y_q     <= 4'd1;
            cen_q   <= 24'd0;
            rad_q   <= 12'd0;
            mode_q  <= MODE_A;
        end else begin
            case (state_q)
                IDLE: if (en) begin
                    cen_q   <= central;
                    rad_q   <= radius;
                    mode_q  <= mode;
                    cnt_q   <= 8'd0;
                    x_q     <= 4'd1;
                    y_q     <= 4'd1;
                    busy_q  <= 1'b1;
                    state_q <= SCAN;
                end
                SCAN: begin
                    cnt_q <= cnt_q + {6'b0, inc_d};
                    if (last_d) state_q <= DONE;
                    x_q <= row_end_d ? 4'd1 : x_q + x_step_d;
                    y_q <= row_end_d ? y_q + 4'd1 : y_q;
                end
                DONE: if (!valid_q) begin
                    valid_q <= 1'b1;
                    cand_q  <= cnt_q;
                end else begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign candidate = cand_q;
endmodule

// File: tb/tb_set_circle_counter.sv
// tb_set_circle_counter: directed table, handshake corner cases and random jobs against a lattice model.
module tb_set_circle_counter;
    localparam int GRID = 8;
`ifdef SET_DUAL_POINT_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 65;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [23:0] central = 24'd0;
    logic [11:0] radius = 12'd0;
    logic [1:0]  mode = 2'd0;
    logic        busy, valid;
    logic [7:0]  candidate;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] c;
        logic [11:0] r;
        logic [1:0]  m;
        int          exp;
    } vec_t;

    always #5 clk = ~clk;

    set_circle_counter #(.GRID(GRID)) dut (
        .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius),
        .mode(mode), .busy(busy), .valid(valid), .candidate(candidate)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // direct enumeration of the lattice from the membership rules
    function automatic int model(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        int n = 0;
        for (int y = 1; y <= GRID; y++) begin
            for (int x = 1; x <= GRID; x++) begin
                int hit [3];
                int k;
                for (int i = 0; i < 3; i++) begin
                    int cx = int'((c >> (20 - 8*i)) & 24'hF);
                    int cy = int'((c >> (16 - 8*i)) & 24'hF);
                    int rr = int'((r >> (8 - 4*i)) & 12'hF);
                    hit[i] = ((x-cx)*(x-cx) + (y-cy)*(y-cy) <= rr*rr) ? 1 : 0;
                end
                k = hit[0] + hit[1] + hit[2];
                case (m)
                    2'd0: n += hit[0];
                    2'd1: n += hit[0] & hit[1];
                    2'd2: n += hit[0] ^ hit[1];
                    default: n += (k == 2) ? 1 : 0;
                endcase
            end
        end
        return n;
    endfunction

    task automatic run_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                           input bit poke, output int res);
        int lat;
        @(negedge clk);
        central = c; radius = r; mode = m; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        central = 24'($urandom); radius = 12'($urandom); mode = 2'($urandom);
        check("busy_after_accept", int'(busy), 1);
        lat = 0;
        while (!valid && lat < 300) begin
            if (poke && (lat == 10 || lat == 20)) en = 1'b1;
            @(posedge clk); #1;
            lat++;
            en = 1'b0;
        end
        check("latency", lat, LAT);
        res = int'(candidate);
        check("busy_at_valid", int'(busy), 1);
        @(posedge clk); #1;
        check("valid_one_cycle", int'(valid), 0);
        check("busy_fall", int'(busy), 0);
    endtask

    initial begin
        vec_t tab [6];
        int res, res2, saw;
        tab[0] = '{24'h110000, 12'hF00, 2'b00, 64};
        tab[1] = '{24'h440000, 12'h000, 2'b00, 1};
        tab[2] = '{24'h440000, 12'h100, 2'b00, 5};
        tab[3] = '{24'h445400, 12'h110, 2'b01, 2};
        tab[4] = '{24'h445400, 12'h110, 2'b10, 6};
        tab[5] = '{24'h445444, 12'h110, 2'b11, 1};

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_candidate", int'(candidate), 0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_job(tab[i].c, tab[i].r, tab[i].m, 1'b0, res);
            check($sformatf("table_%0d", i), res, tab[i].exp);
        end

        run_job(tab[5].c, tab[5].r, tab[5].m, 1'b1, res);
        check("en_during_busy", res, 1);

        run_job(tab[4].c, tab[4].r, tab[4].m, 1'b0, res);
        run_job(tab[4].c, tab[4].r, tab[4].m, 1'b0, res2);
        check("back_to_back_first", res, 6);
        check("back_to_back_second", res2, res);

        run_job(24'h000000, 12'h000, 2'b00, 1'b0, res);
        check("off_grid_center", res, 0);
        run_job(24'hFF0000, 12'hF00, 2'b00, 1'b0, res);
        check("far_corner", res, model(24'hFF0000, 12'hF00, 2'b00));

        for (int i = 0; i < 16; i++) begin
            logic [23:0] c;
            logic [11:0] r;
            logic [1:0]  m;
            c = 24'($urandom);
            r = 12'($urandom);
            m = 2'($urandom_range(0, 3));
            run_job(c, r, m, 1'b0, res);
            check($sformatf("random_%0d", i), res, model(c, r, m));
        end

        @(negedge clk);
        central = 24'h110000; radius = 12'hF00; mode = 2'b00; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midscan_reset_busy", int'(busy), 0);
        check("midscan_reset_valid", int'(valid), 0);
        check("midscan_reset_candidate", int'(candidate), 0);
        rst = 1'b1;
        saw = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (valid || busy) saw = 1;
        end
        check("midscan_reset_no_valid", saw, 0);

        run_job(tab[2].c, tab[2].r, tab[2].m, 1'b0, res);
        check("after_abort", res, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
